// File: rtl/umi_sink_checker_pkg.sv
// Shared encodings and helpers for the UMI sink checker.
package umi_sink_checker_pkg;

    localparam int UMI_CW = 32;
    localparam int UMI_AW = 64;
    localparam int UMI_DW = 512;
    localparam int UMI_PW = UMI_CW + 2*UMI_AW + UMI_DW;

    localparam logic [1:0] MODE_ALWAYS = 2'd0;
    localparam logic [1:0] MODE_TOGGLE = 2'd1;
    localparam logic [1:0] MODE_LFSR   = 2'd2;
    localparam logic [1:0] MODE_STALL  = 2'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/umi_chk_expq.sv
// Expected-packet queue: synchronous FIFO with head-of-queue output.
module umi_chk_expq #(
    parameter int PW    = 640,
    parameter int DEPTH = 8
) (
    input  logic          slowclk,
    input  logic          nreset,
    input  logic          push_i,
    input  logic [PW-1:0] din_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [PW-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]  wr_q, wr_d;
    logic [PTR_W:0]  rd_q, rd_d;
    logic [PW-1:0]   mem_q [DEPTH];
    logic            do_push;
    logic            do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                     (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign head_o  = mem_q[rd_q[PTR_W-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge slowclk or negedge nreset) begin
        if (!nreset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge slowclk) begin
        if (do_push) mem_q[wr_q[PTR_W-1:0]] <= din_i;
    end

endmodule

// File: rtl/umi_sink_checker.sv
// UMI sink: drives a backpressure pattern on ready and checks accepted
// packets, in order, against a queue of expected packets.
//
// state   | meaning
// IDLE    | waiting for go, results cleared
// RUN     | accepting and comparing packets, idle counter armed
// DONE    | results held, done=1, go restarts
module umi_sink_checker
    import umi_sink_checker_pkg::*;
#(
    parameter int CW      = UMI_CW,
    parameter int AW      = UMI_AW,
    parameter int DW      = UMI_DW,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic          slowclk,
    input  logic          nreset,
    input  logic          go,
    input  logic [1:0]    cfg_mode,
    input  logic [15:0]   cfg_count,
    input  logic          exp_valid,
    input  logic [CW-1:0] exp_cmd,
    input  logic [AW-1:0] exp_dstaddr,
    input  logic [AW-1:0] exp_srcaddr,
    input  logic [DW-1:0] exp_data,
    output logic          exp_ready,
    input  logic          umi_in_valid,
    input  logic [CW-1:0] umi_in_cmd,
    input  logic [AW-1:0] umi_in_dstaddr,
    input  logic [AW-1:0] umi_in_srcaddr,
    input  logic [DW-1:0] umi_in_data,
    output logic          umi_in_ready,
    output logic [15:0]   pass_count,
    output logic          error,
    output logic [15:0]   err_index,
    output logic          timeout,
    output logic          done
);

    localparam int PW = CW + 2*AW + DW;
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   accept_q, accept_d;
    logic [15:0]   pass_q, pass_d;
    logic [15:0]   eidx_q, eidx_d;
    logic          error_q, error_d;
    logic          timeout_q, timeout_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          tog_q, tog_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          init_q;

    logic          q_full, q_empty;
    logic [PW-1:0] q_head;
    logic          pat;
    logic          accept;
    logic          match;

    // exp_ready stays low until the first clock after reset releases.
    assign exp_ready = init_q & ~q_full;

    umi_chk_expq #(.PW(PW), .DEPTH(DEPTH)) u_expq (
        .slowclk (slowclk),
        .nreset  (nreset),
        .push_i  (exp_valid & exp_ready),
        .din_i   ({exp_cmd, exp_dstaddr, exp_srcaddr, exp_data}),
        .pop_i   (accept),
        .full_o  (q_full),
        .empty_o (q_empty),
        .head_o  (q_head)
    );

    always_comb begin
        pat = 1'b0;
        case (mode_q)
            MODE_ALWAYS: pat = 1'b1;
            MODE_TOGGLE: pat = tog_q;
            MODE_LFSR:   pat = lfsr_q[0];
            MODE_STALL:  pat = 1'b0;
        endcase
    end

    assign umi_in_ready = (state_q == ST_RUN) & ~q_empty & pat;
    assign accept       = umi_in_valid & umi_in_ready;
    assign match        = (q_head == {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data});

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        count_d   = count_q;
        accept_d  = accept_q;
        pass_d    = pass_q;
        eidx_d    = eidx_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        idle_d    = idle_q;
        tog_d     = tog_q;
        lfsr_d    = lfsr_q;
        case (state_q)
            ST_RUN: begin
                tog_d  = ~tog_q;
                lfsr_d = lfsr_next(lfsr_q);
                if (accept) begin
                    accept_d = sat_inc16(accept_q);
                    idle_d   = '0;
                    if (match) begin
                        pass_d = sat_inc16(pass_q);
                    end else begin
                        error_d = 1'b1;
                        if (!error_q) eidx_d = accept_q;
                    end
                    if (accept_d == count_q) state_d = ST_DONE;
                end else begin
                    idle_d = idle_q + IW'(1);
                    if (idle_q == IW'(TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            default: begin
                if (go) begin
                    if (cfg_count == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_RUN;
                        mode_d    = cfg_mode;
                        count_d   = cfg_count;
                        accept_d  = '0;
                        pass_d    = '0;
                        eidx_d    = '0;
                        error_d   = 1'b0;
                        timeout_d = 1'b0;
                        idle_d    = '0;
                        tog_d     = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge slowclk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_ALWAYS;
            count_q   <= '0;
            accept_q  <= '0;
            pass_q    <= '0;
            eidx_q    <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            idle_q    <= '0;
            tog_q     <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            count_q   <= count_d;
            accept_q  <= accept_d;
            pass_q    <= pass_d;
            eidx_q    <= eidx_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
            idle_q    <= idle_d;
            tog_q     <= tog_d;
            lfsr_q    <= lfsr_d;
            init_q    <= 1'b1;
        end
    end

    assign pass_count = pass_q;
    assign error      = error_q;
    assign err_index  = eidx_q;
    assign timeout    = timeout_q;
    assign done       = (state_q == ST_DONE);

endmodule

// File: doc/umi_sink_checker.md
Name: umi_sink_checker

Overview:
- Downstream consumer on the slowclk domain; terminates the umi_out side of a UMI FIFO/CDC DUT.
- Drives a programmable backpressure pattern on umi_in_ready and compares each accepted packet, in order, against an expected-packet queue loaded on the same clock.
- Reports pass count, sticky error, first-mismatch index, timeout and done for self-checking benches.

Parameters:
- CW, 32, UMI command width
- AW, 64, UMI address width
- DW, 512, UMI data width
- DEPTH, 8, expected-queue depth (power of 2, >=2)
- TIMEOUT, 1024, max cycles in RUN without an accept before the run is aborted

Ports:
- slowclk  in  1  clock
- nreset  in  1  reset (asynchronous, active-low)
- go  in  1  start pulse/level, sampled only in IDLE
- cfg_mode  in  2  ready pattern: 0 always, 1 toggle, 2 LFSR, 3 stall
- cfg_count  in  16  number of packets to check
- exp_valid  in  1  expected-packet push
- exp_cmd / exp_dstaddr / exp_srcaddr / exp_data  in  CW/AW/AW/DW  expected fields
- exp_ready  out  1  queue not full
- umi_in_valid  in  1  DUT output valid
- umi_in_cmd / umi_in_dstaddr / umi_in_srcaddr / umi_in_data  in  CW/AW/AW/DW  DUT packet
- umi_in_ready  out  1  sink ready
- pass_count  out  16  packets accepted and matched
- error  out  1  sticky mismatch
- err_index  out  16  index of first mismatching packet
- timeout  out  1  sticky timeout
- done  out  1  run complete

Behaviour:
- Reset values: all outputs 0; exp_ready 0 during reset, 1 after reset releases (queue empty); LFSR=16'hACE1; toggle bit=0; state IDLE.
- FSM states:
  - IDLE: on go, go to DONE if cfg_count==0, else latch cfg_count and cfg_mode, clear counters/flags, go to RUN.
  - RUN: on accept_cnt==cfg_count, or when the idle counter reaches TIMEOUT, go to DONE.
  - DONE: done=1, hold all results until the next go. Results clear on the IDLE->RUN transition only.
- go is ignored outside IDLE/DONE; a go in DONE behaves as in IDLE.
- umi_in_ready = (state==RUN) & ~q_empty & pat. It never depends on umi_in_valid.
- pat per mode:
  - 0: 1
  - 1: toggle bit, flips every RUN cycle, starts 0
  - 2: lfsr[0], Fibonacci taps 16,14,13,11, advances every RUN cycle
  - 3: 0
- Accept = umi_in_valid & umi_in_ready. Compare all four fields to the queue head combinationally, then pop the head in the same cycle.
- On match: pass_count+1. On mismatch: error<=1; err_index<=accept_cnt only on the first mismatch.
- accept_cnt increments on every accept; it is internal.
- exp_ready = ~q_full. Push occurs when exp_valid & exp_ready.
  - Push and pop in the same cycle on a full queue: push is rejected, because exp_ready is derived from full only.
  - Push into an empty queue does not bypass; the packet becomes visible to ready the next cycle.
- Push is allowed in any state. Residual queue entries persist across runs.
- Idle counter: clears on accept or on entering RUN, increments each RUN cycle otherwise. At TIMEOUT: timeout<=1, go to DONE.
- Mode 3 always times out.
- Counters saturate at 16'hFFFF.
- Asynchronous reset mid-run: everything returns to reset values, including the queue (flushed) and the LFSR.

Decomposition:
- Shared header umi_sink_checker_pkg: mode encodings (MODE_ALWAYS, MODE_TOGGLE, MODE_LFSR, MODE_STALL), LFSR_SEED, state encodings, PW=CW+2*AW+DW.
- One sub-module, umi_chk_expq: synchronous FIFO of PW-bit entries with push/pop/full/empty and head output.

Test Plan:
- Mode 0, cfg_count=4: push 4 packets (data=1..4), DUT sends identical packets back-to-back -> 4 accepts in 4 consecutive cycles, pass_count=4, error=0, done=1.
- Mode 1, cfg_count=3: push 3 packets, valid held high -> ready pattern 0,1,0,1,0,1, accepts on cycles 2/4/6, pass_count=3.
- Mode 0, cfg_count=5: packet 2 has dstaddr mismatch (0x100 vs 0x104), packet 4 has data mismatch -> error=1, err_index=2, pass_count=3, done=1.
- Mode 3, TIMEOUT=16: go with queue loaded -> umi_in_ready stays 0, timeout=1 and done=1 exactly 16 cycles after RUN entry.
- Fill the queue to DEPTH=8 -> exp_ready=0. Simultaneous push+pop -> push dropped, occupancy becomes 7, exp_ready=1 the next cycle.
- Mid-run reset after 2 of 4 accepts -> all outputs 0, queue empty. A new go with cfg_count=0 -> done=1 one cycle later, pass_count=0.
